// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter: owner tag encoding,
// default parameter values and the byte-to-word address offset.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_IF    = 2'd1,
        TAG_DM_RD = 2'd2
    } tag_t;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_MEM_ADDR_WIDTH = 10;
    localparam int DEF_MEM_LATENCY    = 1;
    localparam int DEF_STARVE_LIMIT   = 4;

    localparam int BYTE_OFFSET = 2;

    function automatic tag_t squash_if(input tag_t t);
        return (t == TAG_IF) ? TAG_NONE : t;
    endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Shift register of access-owner tags matching the RAM read latency, with
// synchronous clear and a squash input that kills in-flight fetch tags.
module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MEM_LATENCY
) (
    input  logic clk,
    input  logic srst,
    input  logic squash_if_en,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_reg  [DEPTH];
    tag_t stage_next [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = tag_in;
            end else begin : g_body
                assign stage_next[gi] = squash_if_en ? squash_if(stage_reg[gi-1])
                                                     : stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= TAG_NONE;
            end
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-port RAM and
// steers read data back by owner tag. Optional fetch starvation guard: ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int MEM_LATENCY    = DEF_MEM_LATENCY,
    parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    input  logic                      if_flush,
    output logic                      if_gnt,
    output logic                      if_rvalid,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    input  logic                      dm_req,
    input  logic                      dm_we,
    input  logic [3:0]                dm_be,
    input  logic [ADDR_WIDTH-1:0]     dm_addr,
    input  logic [DATA_WIDTH-1:0]     dm_wdata,
    output logic                      dm_gnt,
    output logic                      dm_rvalid,
    output logic [DATA_WIDTH-1:0]     dm_rdata,
    output logic                      mem_en,
    output logic [3:0]                mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int WA_HI = MEM_ADDR_WIDTH + BYTE_OFFSET - 1;

    logic grant_if;
    logic grant_dm;
    logic fetch_first;
    tag_t tag_in;
    tag_t tag_tail;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt_reg;

    // Never exceeds the limit: at the limit a waiting, unflushed fetch wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else if (grant_if || !if_req) begin
            starve_cnt_reg <= '0;
        end else if (grant_dm && !if_flush) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

    assign fetch_first = (starve_cnt_reg >= CNT_W'(STARVE_LIMIT));
`else
    localparam int UNUSED_STARVE_LIMIT = STARVE_LIMIT;
    assign fetch_first = 1'b0;
`endif

    assign grant_if = !rst && if_req && !if_flush && (!dm_req || fetch_first);
    assign grant_dm = !rst && dm_req && !grant_if;
    assign if_gnt   = grant_if;
    assign dm_gnt   = grant_dm;

    always_comb begin
        mem_en    = grant_if || grant_dm;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_dm) begin
            mem_addr = dm_addr[WA_HI:BYTE_OFFSET];
            if (dm_we) begin
                mem_we    = dm_be;
                mem_wdata = dm_wdata;
            end
        end else if (grant_if) begin
            mem_addr = if_addr[WA_HI:BYTE_OFFSET];
        end
    end

    // Stores carry no return, so they ride the pipe as empty slots.
    assign tag_in = grant_if              ? TAG_IF    :
                    (grant_dm && !dm_we)  ? TAG_DM_RD : TAG_NONE;

    mem_arb_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk          (clk),
        .srst         (rst),
        .squash_if_en (if_flush),
        .tag_in       (tag_in),
        .tag_out      (tag_tail)
    );

    // A flush also kills the fetch that would return in the flush cycle itself.
    assign if_rvalid = !rst && !if_flush && (tag_tail == TAG_IF);
    assign dm_rvalid = !rst && (tag_tail == TAG_DM_RD);
    assign if_rdata  = rst ? '0 : mem_rdata;
    assign dm_rdata  = rst ? '0 : mem_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr, dm_addr};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a RAM emulation and
// a scoreboard model built from the arbitration and latency rules.
module tb_mem_port_arbiter;

    localparam int L     = 2;
    localparam int LIMIT = 4;
    localparam int WORDS = 1024;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MEM_ADDR_WIDTH (10),
        .MEM_LATENCY    (L),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int a);
        return (a * 32'h0100_0193) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // RAM emulation: write-first single port driven only by the DUT's mem_* outputs.
    logic [31:0] ram_w       [WORDS];
    bit          ram_written [WORDS];
    logic [31:0] rd_pipe     [L];

    function automatic logic [31:0] ram_rd(input int a);
        return ram_written[a] ? ram_w[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            ram_w[mem_addr]       <= merge(ram_rd(int'(mem_addr)), mem_wdata, mem_we);
            ram_written[mem_addr] <= 1'b1;
            rd_pipe[0]            <= merge(ram_rd(int'(mem_addr)), mem_wdata, mem_we);
        end else begin
            rd_pipe[0] <= 32'hBAD0_0000;
        end
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[L-1];

    // Reference model: scoreboard of expected returns keyed by return cycle.
    logic [31:0] m_mem     [WORDS];
    bit          m_written [WORDS];
    bit          sb_if_v   [8];
    logic [31:0] sb_if_d   [8];
    bit          sb_dm_v   [8];
    logic [31:0] sb_dm_d   [8];
    int          m_cnt = 0;
    int          cyc = 0;

    function automatic logic [31:0] model_rd(input logic [31:0] byte_addr);
        int a;
        a = int'((byte_addr >> 2) % WORDS);
        return m_written[a] ? m_mem[a] : init_word(a);
    endfunction

    initial begin
        bit          e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, store;
        logic [31:0] e_dm_d, e_if_d, e_addr;
        int          slot, ns, wa;
        forever begin
            @(negedge clk);
            e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0;
            e_if_d = '0; e_dm_d = '0; e_addr = '0;
            slot = cyc % 8;
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    sb_if_v[i] = 0;
                    sb_dm_v[i] = 0;
                end
                m_cnt = 0;
            end else begin
                if (if_flush) begin
                    for (int i = 0; i < 8; i++) sb_if_v[i] = 0;
                end
                e_if_rv = sb_if_v[slot]; e_if_d = sb_if_d[slot];
                e_dm_rv = sb_dm_v[slot]; e_dm_d = sb_dm_d[slot];
                if (if_req && !if_flush && (!dm_req || (GUARD && m_cnt >= LIMIT))) e_if_gnt = 1;
                else if (dm_req) e_dm_gnt = 1;
            end
            sb_if_v[slot] = 0;
            sb_dm_v[slot] = 0;
            store = e_dm_gnt && dm_we;

            check("if_gnt", {31'd0, if_gnt}, {31'd0, e_if_gnt});
            check("dm_gnt", {31'd0, dm_gnt}, {31'd0, e_dm_gnt});
            check("mem_en", {31'd0, mem_en}, {31'd0, e_if_gnt | e_dm_gnt});
            check("mem_we", {28'd0, mem_we}, store ? {28'd0, dm_be} : 32'd0);
            check("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_if_rv});
            check("dm_rvalid", {31'd0, dm_rvalid}, {31'd0, e_dm_rv});
            if (e_if_rv) check("if_rdata", if_rdata, e_if_d);
            if (e_dm_rv) check("dm_rdata", dm_rdata, e_dm_d);
            if (e_if_gnt || e_dm_gnt) begin
                e_addr = e_if_gnt ? if_addr : dm_addr;
                check("mem_addr", {22'd0, mem_addr}, (e_addr >> 2) % WORDS);
            end
            if (store) check("mem_wdata", mem_wdata, dm_wdata);

            ns = (cyc + L) % 8;
            if (e_if_gnt) begin
                sb_if_v[ns] = 1;
                sb_if_d[ns] = model_rd(if_addr);
                $display("txn cyc=%0d fetch addr=%h", cyc, if_addr);
            end else if (e_dm_gnt && !dm_we) begin
                sb_dm_v[ns] = 1;
                sb_dm_d[ns] = model_rd(dm_addr);
                $display("txn cyc=%0d load  addr=%h", cyc, dm_addr);
            end else if (store) begin
                wa = int'((dm_addr >> 2) % WORDS);
                m_mem[wa]     = merge(model_rd(dm_addr), dm_wdata, dm_be);
                m_written[wa] = 1;
                $display("txn cyc=%0d store addr=%h be=%b data=%h", cyc, dm_addr, dm_be, dm_wdata);
            end
            if (!rst) begin
                if (e_if_gnt || !if_req) m_cnt = 0;
                else if (e_dm_gnt && !if_flush) m_cnt++;
            end
            cyc++;
        end
    end

    task automatic drive(input logic r, input logic iq, input logic [31:0] ia, input logic fl,
                         input logic dq, input logic we, input logic [3:0] be,
                         input logic [31:0] da, input logic [31:0] wd);
        @(posedge clk);
        #1;
        rst = r; if_req = iq; if_addr = ia; if_flush = fl;
        dm_req = dq; dm_we = we; dm_be = be; dm_addr = da; dm_wdata = wd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        int n_if, n_dm;
        rst = 1; if_req = 1; if_addr = 32'h40; if_flush = 0;
        dm_req = 1; dm_we = 0; dm_be = 4'h0; dm_addr = 32'h100; dm_wdata = '0;

        // Reset with both requests pending.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h40, 0, 1, 0, 4'h0, 32'h100, 32'h0);
            check("rst_gnt", {30'd0, if_gnt, dm_gnt}, 32'd0);
            check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        end

        // Contention on release: data first, then fetch.
        drive(0, 1, 32'h40, 0, 1, 0, 4'h0, 32'h100, 32'h0);
        check("lit_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        check("lit_dm_addr", {22'd0, mem_addr}, 32'h40);
        drive(0, 1, 32'h40, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("lit_if_gnt", {31'd0, if_gnt}, 32'd1);
        check("lit_if_addr", {22'd0, mem_addr}, 32'h10);
        idle();
        check("lit_dm_rv", {30'd0, if_rvalid, dm_rvalid}, 32'd1);
        check("lit_dm_rdata", dm_rdata, init_word(32'h40));
        idle();
        check("lit_if_rv", {30'd0, if_rvalid, dm_rvalid}, 32'd2);
        check("lit_if_rdata", if_rdata, init_word(32'h10));

        // Full store, partial store, then load of the same word.
        drive(0, 0, 32'h0, 0, 1, 1, 4'hF, 32'h200, 32'h1122_3344);
        drive(0, 0, 32'h0, 0, 1, 1, 4'h3, 32'h200, 32'hDEAD_BEEF);
        drive(0, 0, 32'h0, 0, 1, 0, 4'h0, 32'h200, 32'h0);
        idle();
        check("lit_store_no_rv", {31'd0, dm_rvalid}, 32'd0);
        idle();
        check("lit_load_rv", {31'd0, dm_rvalid}, 32'd1);
        check("lit_load_rdata", dm_rdata, 32'h1122_BEEF);

        // Fetch squashed by a flush one cycle later.
        drive(0, 1, 32'h8, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("lit_fetch8_gnt", {31'd0, if_gnt}, 32'd1);
        drive(0, 1, 32'h20, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        check("lit_flush_no_gnt", {30'd0, if_gnt, mem_en}, 32'd0);
        idle();
        check("lit_flush_no_rv", {31'd0, if_rvalid}, 32'd0);
        idle();

        // Address wrap.
        drive(0, 1, 32'h0000_1004, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("lit_wrap_addr", {22'd0, mem_addr}, 32'h001);
        idle();
        idle();
        idle();

        // Sustained contention.
        n_if = 0; n_dm = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 32'h30 + 32'(4 * i), 0, 1, 0, 4'h0, 32'h300 + 32'(4 * i), 32'h0);
            n_if += int'(if_gnt);
            n_dm += int'(dm_gnt);
        end
        check("lit_starve_if", 32'(n_if), GUARD ? 32'd2 : 32'd0);
        check("lit_starve_dm", 32'(n_dm), GUARD ? 32'd8 : 32'd10);
        idle();
        idle();
        idle();

        // Randomized traffic; requests may change freely before grant.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ia, da;
            ia = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31) * 4);
            da = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), ia,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 2) == 0), 4'($urandom), da, $urandom);
        end
        idle();
        idle();
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
